if_id_stage: RTL and testbench

- IF/ID pipeline register plus load-use hazard detection and control-flow flush for the 5-stage MIPS pipeline.
- Captures the fetched instruction and PC+4 from the fetch stage.
- Drives `pc_write` back to the fetch stage and a bubble request to the ID/EX register.
- Presents pre-split instruction fields to the decode logic.
- Keeps saturating stall and flush event counters for bring-up visibility.

---
 rtl/if_id_stage_if.sv | 38 +++
 rtl/if_id_stage.sv | 105 ++++++++++
 tb/tb_if_id_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch/hazard/decode signal bundle for the IF/ID stage
interface if_id_stage_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instruction;
  logic [31:0]      next_pc;
  logic             branch_taken;
  logic             jump;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rt;

  logic             pc_write;
  logic             id_ex_bubble;
  logic             ifid_valid;
  logic [31:0]      ifid_instruction;
  logic [31:0]      ifid_next_pc;
  logic [5:0]       opcode;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [5:0]       funct;
  logic [31:0]      imm_sext;
  logic [31:0]      jump_address;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output instruction, next_pc, branch_taken, jump, id_ex_mem_read, id_ex_rt,
    input  pc_write, id_ex_bubble, ifid_valid, ifid_instruction, ifid_next_pc,
           opcode, rs, rt, rd, funct, imm_sext, jump_address, stall_count, flush_count
  );

  modport slave (
    input  instruction, next_pc, branch_taken, jump, id_ex_mem_read, id_ex_rt,
    output pc_write, id_ex_bubble, ifid_valid, ifid_instruction, ifid_next_pc,
           opcode, rs, rt, rd, funct, imm_sext, jump_address, stall_count, flush_count
  );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with load-use stall and branch/jump flush
module if_id_stage #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  if_id_stage_if.slave bus
);
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      npc_q, npc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        uses_rt;
  logic        rs_match;
  logic        rt_match;
  logic        hazard;
  logic        flush;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];

  // Only R-type, beq, bne and sw actually read rt as a source operand.
  always_comb begin
    uses_rt = 1'b0;
    case (opcode)
      6'h00, 6'h04, 6'h05, 6'h2B: uses_rt = 1'b1;
      default:                    uses_rt = 1'b0;
    endcase
  end

  assign rs_match = (bus.id_ex_rt == rs);
  assign rt_match = uses_rt && (bus.id_ex_rt == rt);
  assign hazard   = valid_q && bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0)
                    && (rs_match || rt_match);
  // A dependent branch is not trusted, so the stall suppresses the flush.
  assign flush    = (bus.branch_taken || bus.jump) && !hazard;

  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (hazard) begin
      instr_d = instr_q;
      npc_d   = npc_q;
      valid_d = valid_q;
    end else if (flush) begin
      instr_d = NOP_INSTR;
      npc_d   = bus.next_pc;
      valid_d = 1'b0;
    end else begin
      instr_d = bus.instruction;
      npc_d   = bus.next_pc;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (hazard && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
    if (flush && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP_INSTR;
      npc_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_write         = !hazard;
  assign bus.id_ex_bubble     = hazard;
  assign bus.ifid_valid       = valid_q;
  assign bus.ifid_instruction = instr_q;
  assign bus.ifid_next_pc     = npc_q;
  assign bus.opcode           = opcode;
  assign bus.rs               = rs;
  assign bus.rt               = rt;
  assign bus.rd               = instr_q[15:11];
  assign bus.funct            = instr_q[5:0];
  assign bus.imm_sext         = {{16{instr_q[15]}}, instr_q[15:0]};
  assign bus.jump_address     = {npc_q[31:28], instr_q[25:0], 2'b00};
  assign bus.stall_count      = stall_q;
  assign bus.flush_count      = flush_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed vector bench for if_id_stage
module tb_if_id_stage;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  if_id_stage_if #(.CNT_W(CW)) bus ();

  if_id_stage #(.CNT_W(CW), .NOP_INSTR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI8 = 32'h2008_0005;
  localparam logic [31:0] I_ADD   = 32'h012B_5020;
  localparam logic [31:0] I_ADDI9 = 32'h2109_FFFF;
  localparam logic [31:0] I_SW    = 32'hAD09_0000;
  localparam logic [31:0] I_J     = 32'h0800_0010;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        br;
    logic        jmp;
    logic        mrd;
    logic [4:0]  ex_rt;
    logic        e_pcw;
    logic        e_bub;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    logic        e_valid;
    logic [1:0]  e_stall;
    logic [1:0]  e_flush;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic b,
                       input logic j, input logic m, input logic [4:0] r);
    bus.instruction    = i;
    bus.next_pc        = p;
    bus.branch_taken   = b;
    bus.jump           = j;
    bus.id_ex_mem_read = m;
    bus.id_ex_rt       = r;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.ifid_valid}, 32'd0);
    chk({tag, "_instr"}, bus.ifid_instruction, 32'd0);
    chk({tag, "_npc"}, bus.ifid_next_pc, 32'd0);
    chk({tag, "_pcw"}, {31'd0, bus.pc_write}, 32'd1);
    chk({tag, "_bub"}, {31'd0, bus.id_ex_bubble}, 32'd0);
    chk({tag, "_stall"}, {30'd0, bus.stall_count}, 32'd0);
    chk({tag, "_flush"}, {30'd0, bus.flush_count}, 32'd0);
  endtask

  task automatic add(input logic [31:0] i, input logic [31:0] p, input logic b, input logic j,
                     input logic m, input logic [4:0] r, input logic pcw, input logic bub,
                     input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                     input logic [1:0] es, input logic [1:0] ef);
    vec_t v;
    v.instr = i; v.npc = p; v.br = b; v.jmp = j; v.mrd = m; v.ex_rt = r;
    v.e_pcw = pcw; v.e_bub = bub; v.e_instr = ei; v.e_npc = ep; v.e_valid = ev;
    v.e_stall = es; v.e_flush = ef;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] ei;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);

    //   instr    npc           br  j   mrd ex_rt pcw bub  exp_instr exp_npc      v   st  fl
    add(I_ADDI8, 32'h4,        0,  0,  0,  5'd0, 1,  0,   I_ADDI8, 32'h4,       1,  0,  0);
    add(I_ADD,   32'h8,        0,  0,  1,  5'd8, 1,  0,   I_ADD,   32'h8,       1,  0,  0);
    add(I_ADDI9, 32'hC,        0,  0,  1,  5'd9, 0,  1,   I_ADD,   32'h8,       1,  1,  0);
    add(I_ADDI9, 32'hC,        0,  0,  0,  5'd9, 1,  0,   I_ADDI9, 32'hC,       1,  1,  0);
    add(I_SW,    32'h10,       0,  0,  1,  5'd9, 1,  0,   I_SW,    32'h10,      1,  1,  0);
    add(I_ADDI8, 32'h14,       0,  0,  1,  5'd9, 0,  1,   I_SW,    32'h10,      1,  2,  0);
    add(I_ADDI8, 32'h14,       0,  0,  0,  5'd9, 1,  0,   I_ADDI8, 32'h14,      1,  2,  0);
    add(I_ADD,   32'h18,       0,  0,  1,  5'd0, 1,  0,   I_ADD,   32'h18,      1,  2,  0);
    add(I_ADDI8, 32'h1C,       1,  0,  0,  5'd0, 1,  0,   32'h0,   32'h1C,      0,  2,  1);
    add(I_J,     32'h0040_0008,0,  0,  0,  5'd0, 1,  0,   I_J,     32'h0040_0008,1, 2,  1);
    add(I_ADDI8, 32'h0040_000C,0,  1,  0,  5'd0, 1,  0,   32'h0,   32'h0040_000C,0, 2,  2);
    add(I_ADD,   32'h20,       0,  0,  1,  5'd9, 1,  0,   I_ADD,   32'h20,      1,  2,  2);
    add(I_ADDI8, 32'h24,       1,  0,  1,  5'd9, 0,  1,   I_ADD,   32'h20,      1,  3,  2);
    add(I_ADDI8, 32'h24,       1,  1,  1,  5'd11,0,  1,   I_ADD,   32'h20,      1,  3,  2);
    add(I_ADDI8, 32'h28,       1,  0,  0,  5'd9, 1,  0,   32'h0,   32'h28,      0,  3,  3);
    add(I_ADDI8, 32'h2C,       0,  1,  0,  5'd9, 1,  0,   32'h0,   32'h2C,      0,  3,  3);

    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].instr, vecs[k].npc, vecs[k].br, vecs[k].jmp, vecs[k].mrd, vecs[k].ex_rt);
      #1;
      chk($sformatf("v%0d_pcw", k), {31'd0, bus.pc_write}, {31'd0, vecs[k].e_pcw});
      chk($sformatf("v%0d_bub", k), {31'd0, bus.id_ex_bubble}, {31'd0, vecs[k].e_bub});
      if (k == 10) chk("jump_address", bus.jump_address, 32'h0000_0040);
      @(posedge clk);
      #1;
      ei = vecs[k].e_instr;
      chk($sformatf("v%0d_instr", k), bus.ifid_instruction, ei);
      chk($sformatf("v%0d_npc", k), bus.ifid_next_pc, vecs[k].e_npc);
      chk($sformatf("v%0d_valid", k), {31'd0, bus.ifid_valid}, {31'd0, vecs[k].e_valid});
      chk($sformatf("v%0d_stall", k), {30'd0, bus.stall_count}, {30'd0, vecs[k].e_stall});
      chk($sformatf("v%0d_flush", k), {30'd0, bus.flush_count}, {30'd0, vecs[k].e_flush});
      chk($sformatf("v%0d_opcode", k), {26'd0, bus.opcode}, {26'd0, ei[31:26]});
      chk($sformatf("v%0d_rs", k), {27'd0, bus.rs}, {27'd0, ei[25:21]});
      chk($sformatf("v%0d_rt", k), {27'd0, bus.rt}, {27'd0, ei[20:16]});
      chk($sformatf("v%0d_rd", k), {27'd0, bus.rd}, {27'd0, ei[15:11]});
      chk($sformatf("v%0d_funct", k), {26'd0, bus.funct}, {26'd0, ei[5:0]});
      chk($sformatf("v%0d_imm", k), bus.imm_sext, {{16{ei[15]}}, ei[15:0]});
      if (k == 0) begin
        chk("first_rt", {27'd0, bus.rt}, 32'd8);
        chk("first_imm", bus.imm_sext, 32'd5);
      end
      if (k == 3) chk("neg_imm", bus.imm_sext, 32'hFFFF_FFFF);
    end

    // Five back-to-back stalls saturate the 2-bit counter, then reset lands mid-stall.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_state("reset2");
    @(negedge clk);
    rst = 1'b1;
    drive(I_ADD, 32'h30, 1'b0, 1'b0, 1'b0, 5'd9);
    @(negedge clk);
    drive(I_ADDI8, 32'h34, 1'b0, 1'b0, 1'b1, 5'd9);
    for (int s = 0; s < 5; s++) begin
      #1;
      chk($sformatf("sat%0d_bub", s), {31'd0, bus.id_ex_bubble}, 32'd1);
      @(negedge clk);
    end
    chk("sat_stall", {30'd0, bus.stall_count}, 32'd3);
    chk("sat_flush", {30'd0, bus.flush_count}, 32'd0);
    chk("sat_held", bus.ifid_instruction, I_ADD);
    chk("sat_npc", bus.ifid_next_pc, 32'h30);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_valid", {31'd0, bus.ifid_valid}, 32'd1);
    chk("rel_instr", bus.ifid_instruction, I_ADDI8);
    chk("rel_npc", bus.ifid_next_pc, 32'h34);
    chk("rel_stall", {30'd0, bus.stall_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
